// File: rtl/jtframe_ram_streamer_pkg.sv
// Shared types and constants for the RAM fill/stream engine.
package jtframe_ram_streamer_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FILL  = 2'd1,
    READ  = 2'd2,
    DRAIN = 2'd3
  } state_e;

  localparam int FIFO_DEPTH = 4;
  localparam int FIFO_AW    = $clog2(FIFO_DEPTH);

endpackage

// File: rtl/jtframe_ram_streamer_fifo.sv
// Small output FIFO; head word is presented combinationally from the storage flops.
module jtframe_ram_streamer_fifo
  import jtframe_ram_streamer_pkg::*;
#(
  parameter int dw = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               push,
  input  logic               pop,
  input  logic [dw-1:0]      din,
  output logic [dw-1:0]      dout,
  output logic               full,
  output logic               empty,
  output logic [FIFO_AW:0]   occupancy
);

  logic [dw-1:0]        mem_q [FIFO_DEPTH];
  logic [dw-1:0]        mem_d [FIFO_DEPTH];
  logic [FIFO_AW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [FIFO_AW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [FIFO_AW:0]     cnt_q, cnt_d;
  logic                 do_push, do_pop;

  assign full      = (cnt_q == (FIFO_AW+1)'(FIFO_DEPTH));
  assign empty     = (cnt_q == '0);
  assign occupancy = cnt_q;
  assign dout      = mem_q[rd_ptr_q];

  // A pop frees the slot in the same cycle, so push is allowed when full.
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    if (do_push) begin
      mem_d[wr_ptr_q] = din;
      wr_ptr_d        = wr_ptr_q + FIFO_AW'(1);
    end
    if (do_pop) rd_ptr_d = rd_ptr_q + FIFO_AW'(1);
    if (do_push && !do_pop)      cnt_d = cnt_q + (FIFO_AW+1)'(1);
    else if (!do_push && do_pop) cnt_d = cnt_q - (FIFO_AW+1)'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_q    <= '{default: '0};
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

endmodule

// File: rtl/jtframe_ram_streamer.sv
// Fills a RAM region with a constant or streams a region out through a 4-deep FIFO.
//
// state | meaning
// IDLE  | waiting for start; first write/read is issued on the start edge
// FILL  | writing fill_data to consecutive addresses
// READ  | issuing reads while FIFO room (occupancy + in flight) allows
// DRAIN | all reads issued, waiting for the stream to empty
module jtframe_ram_streamer
  import jtframe_ram_streamer_pkg::*;
#(
  parameter int dw = 8,
  parameter int aw = 10
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic          fill,
  input  logic [aw-1:0] base,
  input  logic [aw-1:0] len,
  input  logic [dw-1:0] fill_data,
  output logic          busy,
  output logic          done,
  output logic [aw-1:0] ram_addr,
  output logic [dw-1:0] ram_data,
  output logic          ram_we,
  input  logic [dw-1:0] ram_q,
  output logic [dw-1:0] st_data,
  output logic          st_valid,
  input  logic          st_ready
);

  state_e          state_q, state_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;
  logic            we_q, we_d;
  logic [aw-1:0]   addr_q, addr_d;
  logic [dw-1:0]   wdata_q, wdata_d;
  logic [aw:0]     remain_q, remain_d;
  logic            rd_p1_q, rd_p1_d;
  logic            rd_p2_q;

  logic [aw:0]        len_words;
  logic [FIFO_AW:0]   occupancy;
  logic [FIFO_AW+1:0] pending;
  logic               fifo_full, fifo_empty, pop, can_issue, last_out;

  jtframe_ram_streamer_fifo #(.dw(dw)) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (rd_p2_q),
    .pop       (pop),
    .din       (ram_q),
    .dout      (st_data),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .occupancy (occupancy)
  );

  assign len_words = (len == '0) ? {1'b1, {aw{1'b0}}} : {1'b0, len};
  assign st_valid  = !fifo_empty;
  assign pop       = st_valid && st_ready;
  // rd_p1: address on the bus this cycle; rd_p2: ram_q valid, pushed next edge.
  assign pending   = {1'b0, occupancy} + {{(FIFO_AW+1){1'b0}}, rd_p1_q}
                   + {{(FIFO_AW+1){1'b0}}, rd_p2_q};
  assign can_issue = !fifo_full && (pending < (FIFO_AW+2)'(FIFO_DEPTH));
  assign last_out  = pop && (occupancy == (FIFO_AW+1)'(1)) && !rd_p1_q && !rd_p2_q;

  always_comb begin
    state_d  = state_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    we_d     = we_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    remain_d = remain_q;
    rd_p1_d  = 1'b0;
    unique case (state_q)
      IDLE: begin
        we_d = 1'b0;
        if (start) begin
          busy_d   = 1'b1;
          addr_d   = base;
          remain_d = len_words - (aw+1)'(1);
          if (fill) begin
            state_d = FILL;
            we_d    = 1'b1;
            wdata_d = fill_data;
          end else begin
            state_d = READ;
            rd_p1_d = 1'b1;
          end
        end
      end
      FILL: begin
        if (remain_q == '0) begin
          we_d    = 1'b0;
          done_d  = 1'b1;
          busy_d  = 1'b0;
          state_d = IDLE;
        end else begin
          addr_d   = addr_q + aw'(1);
          remain_d = remain_q - (aw+1)'(1);
        end
      end
      READ: begin
        if (remain_q == '0) begin
          state_d = DRAIN;
        end else if (can_issue) begin
          addr_d   = addr_q + aw'(1);
          remain_d = remain_q - (aw+1)'(1);
          rd_p1_d  = 1'b1;
          if (remain_q == (aw+1)'(1)) state_d = DRAIN;
        end
      end
      DRAIN: begin
        if (last_out) begin
          done_d  = 1'b1;
          busy_d  = 1'b0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      we_q     <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      remain_q <= '0;
      rd_p1_q  <= 1'b0;
      rd_p2_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      we_q     <= we_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      remain_q <= remain_d;
      rd_p1_q  <= rd_p1_d;
      rd_p2_q  <= rd_p1_q;
    end
  end

  assign busy     = busy_q;
  assign done     = done_q;
  assign ram_we   = we_q;
  assign ram_addr = addr_q;
  assign ram_data = wdata_q;

endmodule

// File: doc/jtframe_ram_streamer.md
JTFRAME_RAM_STREAMER -- requirements
Module: jtframe_ram_streamer

Interface
REQ-001 Parameter dw, default 8: RAM and stream data width in bits.
REQ-002 Parameter aw, default 10: RAM address width; memory holds 2**aw words.
REQ-003 Port clk  input  1: single clock for all logic.
REQ-004 Port rst_n  input  1: reset, asynchronous and active-low.
REQ-005 Port start  input  1: one-cycle request to begin a transfer.
REQ-006 Port fill  input  1: mode, sampled with start; 1 = fill RAM with a value, 0 = read RAM out to the stream.
REQ-007 Port base  input  aw: first RAM address, sampled with start.
REQ-008 Port len  input  aw: word count, sampled with start; 0 means 2**aw words.
REQ-009 Port fill_data  input  dw: fill value, sampled with start.
REQ-010 Port busy  output  1: high while a transfer is active.
REQ-011 Port done  output  1: one-cycle pulse when a transfer completes.
REQ-012 Port ram_addr  output  aw: registered RAM address, for one dual-RAM port with clock enable tied high.
REQ-013 Port ram_data  output  dw: registered RAM write data.
REQ-014 Port ram_we  output  1: registered RAM write enable.
REQ-015 Port ram_q  input  dw: RAM read data, valid one clock after ram_addr is presented.
REQ-016 Port st_data  output  dw: stream data.
REQ-017 Port st_valid  output  1: stream word available.
REQ-018 Port st_ready  input  1: sink accepts; a word transfers on a clock edge where st_valid and st_ready are both high.

Function
REQ-019 The FSM SHALL have four states.
- IDLE
- FILL
- READ
- DRAIN: all reads issued, waiting for the stream to empty.
REQ-020 In IDLE, start SHALL latch fill, base, len and fill_data; the next state is FILL if fill=1, else READ; busy rises on the next cycle.
REQ-021 start while busy SHALL be ignored.
REQ-022 FILL SHALL write fill_data to consecutive addresses, one per cycle, starting at base.
- ram_we=1 for exactly the latched word count.
- Then ram_we=0, done pulses on the cycle after the last write, and the FSM returns to IDLE.
REQ-023 READ SHALL issue reads to consecutive addresses starting at base, with ram_we=0; each ram_q word is captured into a 4-entry FIFO one clock after its address.
REQ-024 A read SHALL be issued only when (FIFO occupancy + reads in flight) < 4, so the FIFO never overflows and no word is lost.
REQ-025 With st_ready held high, READ SHALL sustain one word per cycle after an initial latency of 3 cycles from start to the first st_valid.
REQ-026 When the last read is issued, the FSM SHALL enter DRAIN.
- In DRAIN, after the final word is accepted on the stream, done pulses the next cycle and the FSM returns to IDLE.
REQ-027 Words SHALL appear on the stream in address order.
- st_data is stable and st_valid is not deasserted until the word is accepted.
REQ-028 Addresses SHALL increment modulo 2**aw, wrapping from 2**aw-1 to 0.
REQ-029 The word counter SHALL be aw+1 bits wide so that len=0 transfers exactly 2**aw words.
REQ-030 The FIFO SHALL support a push and a pop in the same cycle when full, with occupancy unchanged.

Reset
REQ-031 rst_n low SHALL immediately (asynchronously) force all of the following, at any point including mid-transfer:
- state IDLE;
- busy=0, done=0, ram_we=0, st_valid=0;
- ram_addr=0, ram_data=0, st_data=0;
- FIFO empty, in-flight count 0.
REQ-032 After reset release, no RAM write or stream word SHALL occur until a new start.

Structure
REQ-033 A shared package jtframe_ram_streamer_pkg SHALL hold:
- the state encodings IDLE=0, FILL=1, READ=2, DRAIN=3;
- the FIFO depth constant 4.
REQ-034 The FIFO SHALL be the sub-module jtframe_ram_streamer_fifo (parameter dw; push, pop, full, empty, occupancy); all other logic stays in the top level.

Verification (aw=4, dw=8)
REQ-035 Fill: start with fill=1, base=2, len=3, fill_data=8'hA5 -> exactly 3 writes to addresses 2,3,4, then one done pulse.
REQ-036 Read full speed: RAM preloaded with mem[i]=i, start with fill=0, base=0, len=5, st_ready=1 -> stream 00,01,02,03,04 on consecutive cycles, first st_valid 3 cycles after start, done once.
REQ-037 Wrap and len=0: read with base=14, len=0 -> 16 words 0E,0F,00..0D in order.
REQ-038 Backpressure: st_ready toggles at random with 25% duty, len=8 -> no loss, duplication or reordering; at most 4 reads outstanding; st_data held while stalled.
REQ-039 Reset mid-transfer: rst_n low during a READ after 2 words -> all outputs at reset values within the same cycle; a later start with base=0, len=2 streams 00,01.
REQ-040 start while busy: second start during a fill -> ignored; write count and done pulse match the first request only.
